// File: rtl/hazard_pkg.sv
// Shared types for the D-stage hazard scoreboard: Tuse/Tnew, stage records.
// Stage records carry a fixed-width rd; the scoreboard zero-extends ADDR_W.
package hazard_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] tnew_t;

  localparam tuse_t TUSE_NONE = 2'd3;
  localparam int RD_W_MAX = 8;

  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  typedef struct packed {
    logic [RD_W_MAX-1:0] rd;
    logic                write;
    tnew_t               tnew;
    logic                md_start;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  function automatic tnew_t tnew_dec(tnew_t t);
    return (t == 2'd0) ? t : t - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div occupancy countdown: loads MULT_LAT or DIV_LAT, busy while nonzero.
// A load request is ignored while a countdown is still running.
import hazard_pkg::*;

module md_busy_timer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam int LAT_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat;

  assign lat  = div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load && !busy) begin
      cnt <= lat;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: stall/forward selection and HI/LO interlock.
// Optional perf counters (stall_cnt, hl_stall_cnt) under HAZARD_PERF_EN.
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int ADDR_W   = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [1:0]        d_tuse_rs,
  input  logic [1:0]        d_tuse_rt,
  input  logic [ADDR_W-1:0] d_rd,
  input  logic              d_write,
  input  logic [1:0]        d_tnew,
  input  logic              d_usehl,
  input  logic              d_md_start,
  input  logic              d_md_div,
  output logic              stall,
  output logic [2:0]        fwd_rs_sel,
  output logic [2:0]        fwd_rt_sel,
  output logic              md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       hl_stall_cnt
`endif
);

  stage_rec_t stg [DEPTH:1];
  stage_rec_t d_rec;
  logic       md_div_q;
  logic       busy_w;

  logic       rs_hit, rt_hit;
  tnew_t      rs_tnew, rt_tnew;
  logic [2:0] rs_sel, rt_sel;
  logic       stall_data, stall_hl, stall_any;

  function automatic logic is_prod(stage_rec_t s, logic [ADDR_W-1:0] r);
    return s.write && (r != '0) && (s.rd == RD_W_MAX'(r));
  endfunction

  always_comb begin
    d_rec          = STAGE_BUBBLE;
    d_rec.rd       = RD_W_MAX'(d_rd);
    d_rec.write    = d_write;
    d_rec.tnew     = d_tnew;
    d_rec.md_start = d_md_start;
  end

  // Walk oldest to youngest so the youngest producer wins.
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    rs_tnew = '0;
    rt_tnew = '0;
    rs_sel  = '0;
    rt_sel  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (is_prod(stg[k], d_rs)) begin
        rs_hit  = 1'b1;
        rs_tnew = stg[k].tnew;
        rs_sel  = 3'(k);
      end
      if (is_prod(stg[k], d_rt)) begin
        rt_hit  = 1'b1;
        rt_tnew = stg[k].tnew;
        rt_sel  = 3'(k);
      end
    end
  end

  assign stall_data = d_valid && (
    (d_tuse_rs != TUSE_NONE && rs_hit && rs_tnew > d_tuse_rs) ||
    (d_tuse_rt != TUSE_NONE && rt_hit && rt_tnew > d_tuse_rt));

  assign stall_hl = d_valid && d_usehl &&
                    (stg[STG_E].md_start || busy_w);

  assign stall_any  = !reset && (stall_data || stall_hl);
  assign stall      = stall_any;
  assign fwd_rs_sel = reset ? 3'd0 : rs_sel;
  assign fwd_rt_sel = reset ? 3'd0 : rt_sel;
  assign md_busy    = !reset && busy_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) stg[k] <= STAGE_BUBBLE;
      md_div_q <= 1'b0;
    end else begin
      if (stall_any || flush || !d_valid) begin
        stg[STG_E] <= STAGE_BUBBLE;
      end else begin
        stg[STG_E] <= d_rec;
      end
      md_div_q <= d_md_div;
      for (int k = 2; k <= DEPTH; k++) begin
        stg[k]      <= stg[k-1];
        stg[k].tnew <= tnew_dec(stg[k-1].tnew);
      end
    end
  end

  md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (stg[STG_E].md_start),
    .div   (md_div_q),
    .busy  (busy_w)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      hl_stall_cnt <= '0;
    end else begin
      if (stall_any) stall_cnt <= stall_cnt + 32'd1;
      if (stall_hl) hl_stall_cnt <= hl_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expectation queue.
// Perf counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_scoreboard;

  localparam int DEPTH    = 3;
  localparam int ADDR_W   = 5;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid, flush;
  logic [ADDR_W-1:0] d_rs, d_rt, d_rd;
  logic [1:0]        d_tuse_rs, d_tuse_rt, d_tnew;
  logic              d_write, d_usehl, d_md_start, d_md_div;
  logic              stall, md_busy;
  logic [2:0]        fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0]       stall_cnt, hl_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       busy;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .flush        (flush),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_tuse_rs    (d_tuse_rs),
    .d_tuse_rt    (d_tuse_rt),
    .d_rd         (d_rd),
    .d_write      (d_write),
    .d_tnew       (d_tnew),
    .d_usehl      (d_usehl),
    .d_md_start   (d_md_start),
    .d_md_div     (d_md_div),
    .stall        (stall),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .md_busy      (md_busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .hl_stall_cnt (hl_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v,
                       input logic [ADDR_W-1:0] rs, input logic [1:0] trs,
                       input logic [ADDR_W-1:0] rt, input logic [1:0] trt,
                       input logic [ADDR_W-1:0] rd, input logic wr,
                       input logic [1:0] tn, input logic hl,
                       input logic ms, input logic md);
    d_valid = v;  flush = 1'b0;
    d_rs = rs;    d_tuse_rs = trs;
    d_rt = rt;    d_tuse_rt = trt;
    d_rd = rd;    d_write = wr;    d_tnew = tn;
    d_usehl = hl; d_md_start = ms; d_md_div = md;
  endtask

  task automatic idle();
    set_d(1'b0, 0, 3, 0, 3, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push expectation, compare at negedge, return just after the next posedge.
  task automatic step(input string tag, input logic s,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic b);
    exp_t e;
    e.tag = tag; e.stall = s; e.rs = rs; e.rt = rt; e.busy = b;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    check({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
    check({e.tag, ".fwd_rs"}, 32'(fwd_rs_sel), 32'(e.rs));
    check({e.tag, ".fwd_rt"}, 32'(fwd_rt_sel), 32'(e.rt));
    check({e.tag, ".md_busy"}, 32'(md_busy), 32'(e.busy));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < DEPTH; i++) step("drain", 0, 0, 0, 0);
  endtask

  // Producer with Tnew=tn, then a Tuse=0 consumer of the same register.
  task automatic prod_cons(input logic [ADDR_W-1:0] r, input logic [1:0] tn);
    int n;
    n = int'(tn);
    set_d(1, 0, 3, 0, 3, r, 1, tn, 0, 0, 0);
    step("prod", 0, 0, 0, 0);
    set_d(1, r, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step("use_stall", 1, 3'(i + 1), 0, 0);
    step("use_go", 0, (n + 1 <= DEPTH) ? 3'(n + 1) : 3'd0, 0, 0);
    drain();
  endtask

  // Mult/div issue followed by an mfhi-style HI/LO reader.
  task automatic md_hl(input logic div);
    int lat;
    lat = div ? DIV_LAT : MULT_LAT;
    set_d(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, div);
    step("md_issue", 0, 0, 0, 0);
    set_d(1, 0, 3, 0, 3, 2, 1, 1, 1, 0, 0);
    for (int i = 0; i <= lat; i++) step("hl_stall", 1, 0, 0, i != 0);
    step("hl_release", 0, 0, 0, 0);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    set_d(1, 3, 0, 5, 0, 0, 0, 0, 1, 0, 0);
    step("reset_state", 0, 0, 0, 0);
    reset = 1'b0;
    drain();

    // addu $3 (Tnew 1) then beq on $3 (Tuse 0)
    set_d(1, 0, 3, 0, 3, 3, 1, 1, 0, 0, 0);
    step("addu", 0, 0, 0, 0);
    set_d(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("beq_stall", 1, 1, 0, 0);
    step("beq_fwd", 0, 2, 0, 0);
    drain();

    // $5 in stages 1 and 2; youngest wins
    set_d(1, 0, 3, 0, 3, 5, 1, 2, 0, 0, 0);
    step("lw5", 0, 0, 0, 0);
    set_d(1, 0, 3, 0, 3, 5, 1, 1, 0, 0, 0);
    step("addu5", 0, 0, 0, 0);
    set_d(1, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0);
    step("use5", 0, 0, 1, 0);
    drain();

    // writes to $0 never forward nor stall
    set_d(1, 0, 3, 0, 3, 0, 1, 1, 0, 0, 0);
    step("wr_r0", 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rd_r0", 0, 0, 0, 0);
    drain();

    // flush and stall together: exactly one bubble, D held
    set_d(1, 0, 3, 0, 3, 7, 1, 2, 0, 0, 0);
    step("lw7", 0, 0, 0, 0);
    set_d(1, 7, 0, 0, 3, 9, 1, 1, 0, 0, 0);
    flush = 1'b1;
    step("flush_stall", 1, 1, 0, 0);
    flush = 1'b0;
    step("held_stall", 1, 2, 0, 0);
    step("held_go", 0, 3, 0, 0);
    set_d(1, 9, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    step("use9", 0, 1, 0, 0);
    drain();

    // div then HI/LO reader: 1 + DIV_LAT stall cycles
    md_hl(1'b1);

    // mult countdown aborted by reset at count 4
    set_d(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 0);
    step("mult", 0, 0, 0, 0);
    idle();
    step("mult_load", 0, 0, 0, 0);
    set_d(1, 0, 3, 0, 3, 6, 1, 1, 0, 0, 0);
    step("addu6", 0, 0, 0, 1);
    reset = 1'b1;
    set_d(1, 6, 0, 0, 3, 0, 0, 0, 1, 0, 0);
    step("mid_reset", 0, 0, 0, 0);
    reset = 1'b0;
    step("post_reset", 0, 0, 0, 0);
    drain();

    // 3 + 2 + 2 data-stall cycles, then 11 HI/LO stall cycles
    prod_cons(5'd8, 2'd3);
    prod_cons(5'd9, 2'd2);
    prod_cons(5'd10, 2'd2);
    md_hl(1'b1);
`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt, 32'd18);
    check("hl_stall_cnt", hl_stall_cnt, 32'd11);
`endif

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning post-decode stages tracked (1=E, 2=M, 3=W); legal range 2..6.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-index width.
REQ-003 SHALL have parameter MULT_LAT, default 5, meaning mult busy cycles.
REQ-004 SHALL have parameter DIV_LAT, default 10, meaning div busy cycles.
REQ-005 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-006 SHALL have ports: d_valid  in  1  D holds a real instruction; flush  in  1  kill the instruction entering E.
REQ-007 SHALL have ports: d_rs, d_rt  in  ADDR_W  sources; d_tuse_rs, d_tuse_rt  in  2  Tuse, 3 means unused.
REQ-008 SHALL have ports: d_rd  in  ADDR_W  destination; d_write  in  1  writes GRF; d_tnew  in  2  Tnew at E entry.
REQ-009 SHALL have ports: d_usehl  in  1  reads/writes HI/LO; d_md_start  in  1  issues mult/div; d_md_div  in  1  1=div.
REQ-010 SHALL have ports: stall  out  1  freeze F/D, bubble E; fwd_rs_sel, fwd_rt_sel  out  3  0=GRF, k=stage k.
REQ-011 SHALL have port: md_busy  out  1  MDU occupied.

Function
REQ-012 SHALL hold DEPTH stage records {rd, write, tnew, md_start}; stage 1 loaded from D, stage k from stage k-1 every cycle.
REQ-013 SHALL load tnew into stage 1 as d_tnew and decrement it on each further shift, saturating at 0.
REQ-014 SHALL load a bubble (write=0, md_start=0) into stage 1 when stall, flush or !d_valid.
REQ-015 SHALL treat a stage as a producer for register r iff write=1, rd==r, r!=0.
REQ-016 SHALL set fwd_*_sel to the lowest-numbered (youngest) producer stage, else 0; combinational.
REQ-017 SHALL assert stall_data iff d_valid and, for rs or rt with Tuse!=3, the youngest producer has tnew > Tuse.
REQ-018 SHALL assert stall_hl iff d_valid && d_usehl && (stage-1 md_start || md_busy).
REQ-019 SHALL drive stall = stall_data | stall_hl, combinational, same cycle as D inputs.
REQ-020 SHALL load the busy counter with MULT_LAT or DIV_LAT (per latched d_md_div) on the cycle stage 1 holds md_start; md_busy = counter!=0; counter decrements to 0.
REQ-021 SHALL, on flush and stall in the same cycle, insert exactly one bubble; D is held.
REQ-022 SHALL not reload the busy counter while md_busy is high; a stalled d_md_start with d_usehl is held in D until free.
REQ-023 SHALL ignore fwd/stall contributions from stages whose rd is 0.

Reset
REQ-024 SHALL clear all stage records to bubbles, busy counter to 0, on reset assertion, without waiting for clk.
REQ-025 SHALL drive stall=0, fwd_*_sel=0, md_busy=0 while reset is high; reset mid-countdown aborts the operation.

Configuration
REQ-026 SHALL, with HAZARD_PERF_EN defined, add outputs stall_cnt and hl_stall_cnt (32 bits, wrap at 2^32) counting cycles with stall and stall_hl, cleared by reset.
REQ-027 SHALL, without HAZARD_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-028 SHALL place Tuse/Tnew typedefs, TUSE_NONE=3, stage-record struct and stage-index constants in package hazard_pkg.
REQ-029 SHALL implement the busy counter as sub-module md_busy_timer (load, div, busy); everything else inline.

Verification
REQ-030 SHALL check: addu $3 at E (tnew 1), D beq uses $3 Tuse 0 -> stall=1 one cycle, then fwd_rs_sel=2.
REQ-031 SHALL check: $5 produced in stage 1 and 2 both, D Tuse 1 -> fwd_rt_sel=1 (youngest), stall=0 when tnew<=1.
REQ-032 SHALL check: div issued, then mfhi in D -> stall=1 for 1+DIV_LAT cycles (11), released the next cycle.
REQ-033 SHALL check: reset pulsed at countdown 4 of mult -> md_busy=0 and stall=0 immediately, records empty.
REQ-034 SHALL check: d_rd=0 with write=1 and D reads $0 -> fwd sel 0, no stall; flush+stall same cycle -> single bubble.
REQ-035 SHALL check (HAZARD_PERF_EN): 7 data-stall cycles plus 11 hl-stall cycles -> stall_cnt=18, hl_stall_cnt=11.
